// File: rtl/acc_alu_seq.sv
// acc_alu_seq: sequenced accumulator / register-file ALU.
//
// A WIDTH-bit accumulator A plus an NREG-entry operand register file, driven
// by a three-state sequencer (IDLE -> EXEC -> WB). One command is accepted
// per pass through IDLE, so throughput is one command every three cycles.
//
// Optional feature macro: ACC_ALU_SAT_EN
//   defined   : ADD/ADDI saturate to all-ones on carry-out, SUB clamps to 0
//               on borrow (cf still reports carry/borrow, vf forced to 0).
//   undefined : results wrap modulo 2^WIDTH.
//
// Ports:
//   clk, rst_n          clock (rising edge), asynchronous active-low reset
//   cmd_valid/cmd_ready command handshake
//   cmd_op/reg/data     opcode, register index, immediate operand
//   acc_out             accumulator A
//   rd_sel/rd_data      combinational debug read of R[rd_sel]
//   cf, zf, nf, vf      carry/borrow, zero, negative, signed-overflow flags
//   done                one-cycle pulse when a command retires
//   busy                high in EXEC and WB
//
// Handshake: a command transfers on a rising edge where cmd_valid and
// cmd_ready are both high. cmd_ready is high only in IDLE (and stays low
// until the first edge after reset release); cmd_valid is ignored otherwise.
// The accepted op/reg/data are captured, so the inputs may change freely
// after the transfer edge.
module acc_alu_seq #(
    parameter int WIDTH = 8,
    parameter int NREG  = 4,
    localparam int RW   = $clog2(NREG)
) (
    input  logic             clk,
    input  logic             rst_n,
    input  logic             cmd_valid,
    output logic             cmd_ready,
    input  logic [2:0]       cmd_op,
    input  logic [RW-1:0]    cmd_reg,
    input  logic [WIDTH-1:0] cmd_data,
    output logic [WIDTH-1:0] acc_out,
    input  logic [RW-1:0]    rd_sel,
    output logic [WIDTH-1:0] rd_data,
    output logic             cf,
    output logic             zf,
    output logic             nf,
    output logic             vf,
    output logic             done,
    output logic             busy
);

    localparam logic [2:0] OP_NOP  = 3'b000;
    localparam logic [2:0] OP_LDA  = 3'b001;
    localparam logic [2:0] OP_LDR  = 3'b010;
    localparam logic [2:0] OP_ADD  = 3'b011;
    localparam logic [2:0] OP_SUB  = 3'b100;
    localparam logic [2:0] OP_ADDI = 3'b101;
    localparam logic [2:0] OP_STA  = 3'b110;
    localparam logic [2:0] OP_CLR  = 3'b111;

    typedef enum logic [1:0] {
        S_IDLE = 2'd0,
        S_EXEC = 2'd1,
        S_WB   = 2'd2
    } state_t;

    state_t state, state_next;
    logic   ready_next;
    logic   accept;

    logic [2:0]       op_q;
    logic [RW-1:0]    reg_q;
    logic [WIDTH-1:0] data_q;
    // bit WIDTH carries the cf value (carry for add, borrow for sub)
    logic [WIDTH:0]   res_q;
    logic             ovf_q;
    logic [WIDTH-1:0] regs [NREG];

    logic [WIDTH-1:0] operand;
    logic [WIDTH:0]   sum_add, sum_sub, res_next;
    logic             add_ovf, sub_ovf, ovf_next, borrow;

    assign accept  = cmd_valid && cmd_ready;
    assign rd_data = regs[rd_sel];

    // ---------------- FSM ----------------
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state     <= S_IDLE;
            cmd_ready <= 1'b0;
        end else begin
            state     <= state_next;
            cmd_ready <= ready_next;
        end
    end

    always_comb begin
        state_next = state;
        busy       = 1'b0;
        case (state)
            S_IDLE: if (accept) state_next = S_EXEC;
            S_EXEC: begin
                busy       = 1'b1;
                state_next = S_WB;
            end
            S_WB: begin
                busy       = 1'b1;
                state_next = S_IDLE;
            end
            default: state_next = S_IDLE;
        endcase
        // registered so ready stays low through the reset-release cycle
        ready_next = (state_next == S_IDLE);
    end

    // ---------------- EXEC arithmetic ----------------
    always_comb begin
        operand  = (op_q == OP_ADD || op_q == OP_SUB) ? regs[reg_q] : data_q;
        sum_add  = {1'b0, acc_out} + {1'b0, operand};
        sum_sub  = {1'b0, acc_out} + {1'b0, ~operand} + {{WIDTH{1'b0}}, 1'b1};
        borrow   = ~sum_sub[WIDTH];
        add_ovf  = (acc_out[WIDTH-1] == operand[WIDTH-1]) &&
                   (sum_add[WIDTH-1] != acc_out[WIDTH-1]);
        sub_ovf  = (acc_out[WIDTH-1] != operand[WIDTH-1]) &&
                   (sum_sub[WIDTH-1] != acc_out[WIDTH-1]);
        res_next = {1'b0, data_q};
        ovf_next = 1'b0;
        case (op_q)
            OP_ADD, OP_ADDI: begin
                res_next = sum_add;
                ovf_next = add_ovf;
`ifdef ACC_ALU_SAT_EN
                if (sum_add[WIDTH]) begin
                    res_next = {1'b1, {WIDTH{1'b1}}};
                    ovf_next = 1'b0;
                end
`endif
            end
            OP_SUB: begin
                res_next = {borrow, sum_sub[WIDTH-1:0]};
                ovf_next = sub_ovf;
`ifdef ACC_ALU_SAT_EN
                if (borrow) begin
                    res_next = {1'b1, {WIDTH{1'b0}}};
                    ovf_next = 1'b0;
                end
`endif
            end
            OP_CLR:  res_next = '0;
            default: res_next = {1'b0, data_q};
        endcase
    end

    // ---------------- datapath registers ----------------
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            op_q    <= OP_NOP;
            reg_q   <= '0;
            data_q  <= '0;
            res_q   <= '0;
            ovf_q   <= 1'b0;
            acc_out <= '0;
            cf      <= 1'b0;
            zf      <= 1'b1;
            nf      <= 1'b0;
            vf      <= 1'b0;
            done    <= 1'b0;
            for (int i = 0; i < NREG; i++) regs[i] <= '0;
        end else begin
            done <= 1'b0;
            case (state)
                S_IDLE: begin
                    if (accept) begin
                        op_q   <= cmd_op;
                        reg_q  <= cmd_reg;
                        data_q <= cmd_data;
                    end
                end
                S_EXEC: begin
                    res_q <= res_next;
                    ovf_q <= ovf_next;
                end
                S_WB: begin
                    done <= 1'b1;
                    case (op_q)
                        OP_LDA: begin
                            acc_out <= res_q[WIDTH-1:0];
                            zf      <= (res_q[WIDTH-1:0] == '0);
                            nf      <= res_q[WIDTH-1];
                        end
                        OP_ADD, OP_SUB, OP_ADDI: begin
                            acc_out <= res_q[WIDTH-1:0];
                            cf      <= res_q[WIDTH];
                            zf      <= (res_q[WIDTH-1:0] == '0);
                            nf      <= res_q[WIDTH-1];
                            vf      <= ovf_q;
                        end
                        OP_CLR: begin
                            acc_out <= '0;
                            cf      <= 1'b0;
                            zf      <= 1'b1;
                            nf      <= 1'b0;
                            vf      <= 1'b0;
                        end
                        OP_LDR:  regs[reg_q] <= data_q;
                        OP_STA:  regs[reg_q] <= acc_out;
                        default: ;
                    endcase
                end
                default: ;
            endcase
        end
    end

endmodule

// File: doc/acc_alu_seq.md
Name: acc_alu_seq

Overview:
Parametrised successor to the 8-bit A/B adder-accumulator. Provides a WIDTH-bit accumulator A, an NREG-entry operand register file and a 4-flag ALU (CF/ZF/NF/VF). A 3-state sequencer drives it, taking commands over a valid/ready handshake. It sits between the pin-level input buffer/mode decode and the output mux, replacing the fixed A/B/ALU trio.

Parameters:
WIDTH, 8, datapath width in bits (>=2)
NREG, 4, operand register count (power of 2, >=2); RW = $clog2(NREG)

Ports:
clk  input  1  single clock, rising edge
rst_n  input  1  asynchronous, active-low reset
cmd_valid  input  1  command present
cmd_ready  output  1  block can accept a command (high only in IDLE)
cmd_op  input  3  opcode (see Behaviour)
cmd_reg  input  RW  register index
cmd_data  input  WIDTH  immediate operand
acc_out  output  WIDTH  accumulator A
rd_sel  input  RW  debug read select
rd_data  output  WIDTH  R[rd_sel], combinational
cf  output  1  carry / borrow flag
zf  output  1  zero flag
nf  output  1  negative flag (result MSB)
vf  output  1  signed overflow flag
done  output  1  one-cycle pulse when a command retires
busy  output  1  high in EXEC and WB

Behaviour:
- Reset (async, rst_n=0): state=IDLE; A, all R[i], cf, nf, vf, done = 0; zf = 1. cmd_ready rises with the first clk edge after release.
- Opcodes:
  - 000 NOP: no state change.
  - 001 LDA: A<=data.
  - 010 LDR: R[reg]<=data.
  - 011 ADD: A<=A+R[reg].
  - 100 SUB: A<=A-R[reg].
  - 101 ADDI: A<=A+data.
  - 110 STA: R[reg]<=A.
  - 111 CLR: A<=0.
- FSM:
  - IDLE: cmd_ready=1. On cmd_valid&cmd_ready at edge T, latch op, reg and data; go to EXEC.
  - EXEC: operand = R[reg] or data. Compute a (WIDTH+1)-bit result into the result register; go to WB.
  - WB: write A or R[reg] and update flags; done=1 during the cycle after edge T+2; go to IDLE.
  - Throughput is 1 command per 3 cycles. cmd_valid is ignored outside IDLE. Captured command fields are stable regardless of input changes after acceptance.
- Arithmetic:
  - SUB is computed as A + ~B + 1.
  - ADD/ADDI: cf = carry-out.
  - SUB: cf = borrow (1 iff A < B unsigned).
  - vf = two's-complement overflow.
  - zf = (result == 0); nf = result[WIDTH-1].
  - Results wrap modulo 2^WIDTH.
- Flag updates by opcode:
  - ADD/SUB/ADDI: all four flags.
  - LDA: zf and nf only; cf and vf held.
  - CLR: cf=nf=vf=0, zf=1.
  - NOP/LDR/STA: flags held.
- STA uses A as it stands at WB. No command overlaps another, so there is no hazard.
- Reset asserted during EXEC/WB discards the in-flight command; no partial write occurs.
- cmd_reg out of range cannot occur because NREG is a power of 2.

Optional Feature:
Macro ACC_ALU_SAT_EN.
- Defined: ADD/ADDI saturate to all-ones on unsigned carry-out; SUB clamps to 0 on borrow. cf still reports the carry/borrow. zf, nf and vf are computed on the saturated result, with vf=0 whenever saturation occurs.
- Undefined: results wrap as above.

Test Plan:
- LDA 0xF0; LDR R1=0x20; ADD R1 -> A=0x10, cf=1, zf=0, nf=0, vf=0; done pulses 3 cycles after each accept.
- A=0x10, R1=0x20, SUB R1 -> A=0xF0, cf=1, nf=1, zf=0; then STA R2 -> rd_sel=2 gives rd_data=0xF0.
- LDA 0x7F; ADDI 0x01 -> A=0x80, vf=1, nf=1, cf=0. LDA 0x20; SUB R1(0x20) -> A=0x00, zf=1, cf=0.
- Handshake: hold cmd_valid high with back-to-back ADDI 1 x3 -> exactly 3 accepts, cmd_ready low 2 cycles per command, final A = start+3.
- Assert rst_n=0 during EXEC of LDA 0x55 -> A=0, zf=1, state IDLE, no done pulse.
- With ACC_ALU_SAT_EN: A=0xF0, ADDI 0x20 -> A=0xFF, cf=1; A=0x10, SUB R1(0x20) -> A=0x00, cf=1, zf=1.
